// File: rtl/cb_frame_commutator.sv
// cb_frame_commutator: captures one frame of LANES parallel samples in a
// single beat and streams it out serially (natural or bit-reversed order)
// with valid/ready handshakes on both sides.
// Optional feature macro: CB_PINGPONG_EN adds a shadow bank so that a
// following frame can be accepted while the current one streams, giving
// zero-bubble back-to-back frames.
module cb_frame_commutator #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 8,
  localparam int IDX_W     = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last,
  output logic                          busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  fmode_q, fmode_d;
  logic [DATA_WIDTH-1:0] seg_q [LANES];
  logic [DATA_WIDTH-1:0] seg_d [LANES];

`ifdef CB_PINGPONG_EN
  logic [LANES*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                        smode_q, smode_d;
  logic                        sfull_q, sfull_d;
`endif

  logic [IDX_W-1:0] rev_idx;
  logic [IDX_W-1:0] lane_idx;
  logic             in_accept;
  logic             out_xfer;
  logic             last_beat;

  // Bit-reverse the beat counter and pick the lane for the current beat.
  always_comb begin
    rev_idx = '0;
    for (int unsigned b = 0; b < IDX_W; b++) begin
      rev_idx[b] = cnt_q[IDX_W-1-b];
    end
    lane_idx  = fmode_q ? rev_idx : cnt_q;
    last_beat = (cnt_q == IDX_W'(LANES - 1));
  end

  // Handshake-facing outputs; sample outputs are forced to zero when idle.
  always_comb begin
    out_valid = (state_q == SHIFT);
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = seg_q[lane_idx];
      out_idx  = lane_idx;
      out_last = last_beat;
    end
`ifdef CB_PINGPONG_EN
    in_ready = rst && ((state_q == IDLE) || !sfull_q);
    busy     = (state_q == SHIFT) || sfull_q;
`else
    in_ready = rst && (state_q == IDLE);
    busy     = (state_q == SHIFT);
`endif
    in_accept = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  // Next-state logic: frame load, beat advance, end-of-frame handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fmode_d = fmode_q;
    seg_d   = seg_q;
`ifdef CB_PINGPONG_EN
    shadow_d = shadow_q;
    smode_d  = smode_q;
    sfull_d  = sfull_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_accept) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            seg_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
          fmode_d = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          if (last_beat) begin
            cnt_d = '0;
`ifdef CB_PINGPONG_EN
            // Final beat: promote a waiting shadow frame, else take a frame
            // arriving this very cycle straight into the active bank.
            if (sfull_q) begin
              for (int unsigned k = 0; k < LANES; k++) begin
                seg_d[k] = shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
              end
              fmode_d = smode_q;
              sfull_d = 1'b0;
            end else if (in_accept) begin
              for (int unsigned k = 0; k < LANES; k++) begin
                seg_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
              end
              fmode_d = mode;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef CB_PINGPONG_EN
        if (in_accept && !(out_xfer && last_beat)) begin
          shadow_d = in_data;
          smode_d  = mode;
          sfull_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bank registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fmode_q <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        seg_q[k] <= '0;
      end
`ifdef CB_PINGPONG_EN
      shadow_q <= '0;
      smode_q  <= 1'b0;
      sfull_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fmode_q <= fmode_d;
      seg_q   <= seg_d;
`ifdef CB_PINGPONG_EN
      shadow_q <= shadow_d;
      smode_q  <= smode_d;
      sfull_q  <= sfull_d;
`endif
    end
  end

endmodule
